mem_arbiter: RTL

- Two-requester arbiter and sequencer for the shared 256x8 synchronous memory.
- Accepts independent read/write requests, grants one at a time, and drives the memory enable/rw/address/data controls.
- Captures read data one cycle after issue and returns a single-cycle ack to the winning requester.
- Sits between the test/traffic masters and the memory block, in the same clock domain.

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter and sequencer for a shared synchronous memory.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise requester 0 has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t state_r;
  logic   win_r;
  logic   gnt_any_s;
  logic   gnt1_s;
`ifdef MEM_ARB_RR_EN
  logic   last_gnt_r;
`endif

  // Winner selection, only consumed while the sequencer sits in IDLE
  always_comb begin
    gnt_any_s = req0 | req1;
`ifdef MEM_ARB_RR_EN
    if (req0 && req1) begin
      gnt1_s = ~last_gnt_r;
    end else begin
      gnt1_s = req1;
    end
`else
    if (req0) begin
      gnt1_s = 1'b0;
    end else begin
      gnt1_s = req1;
    end
`endif
  end

  // Access sequencer; every output is a register written here
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      win_r     <= 1'b0;
      mem_en    <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= {DATA_W{1'b0}};
      rdata1    <= {DATA_W{1'b0}};
`ifdef MEM_ARB_RR_EN
      last_gnt_r <= 1'b1;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          if (gnt_any_s) begin
            win_r     <= gnt1_s;
            mem_en    <= 1'b1;
            mem_rw    <= gnt1_s ? rw1 : rw0;
            mem_addr  <= gnt1_s ? addr1 : addr0;
            mem_wdata <= gnt1_s ? wdata1 : wdata0;
`ifdef MEM_ARB_RR_EN
            last_gnt_r <= gnt1_s;
`endif
            state_r   <= ISSUE;
          end else begin
            mem_en  <= 1'b0;
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          if (mem_rw) begin
            ack0    <= ~win_r;
            ack1    <= win_r;
            state_r <= ACK;
          end else begin
            state_r <= CAPTURE;
          end
        end
        CAPTURE: begin
          // Memory read data is valid in this cycle only
          if (win_r) begin
            rdata1 <= mem_rdata;
          end else begin
            rdata0 <= mem_rdata;
          end
          ack0    <= ~win_r;
          ack1    <= win_r;
          state_r <= ACK;
        end
        ACK: begin
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          mem_en  <= 1'b0;
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
